// File: rtl/dt_queue_pkg.sv
// rtl/dt_queue_pkg.sv - shared widths, exception bit layout and SRAM request format for dt_queue
package dt_queue_pkg;

   localparam int DT_EXC_W     = 3;
   localparam int EXC_REFILL   = 0;
   localparam int EXC_INVALID  = 1;
   localparam int EXC_MODIFY   = 2;
   localparam int DATA_SRAM_WD = 70;
   localparam int DT_PAYLOAD_W = 150;

   // Field order of a stored SRAM request, MSB first: en, wen, sel, addr, wdata.
   typedef struct packed {
      logic        en;
      logic        wen;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
   } data_sram_t;

   function automatic logic [DT_EXC_W-1:0] dt_pack_exc(input logic refill,
                                                       input logic invalid,
                                                       input logic modify);
      logic [DT_EXC_W-1:0] e;
      e              = '0;
      e[EXC_REFILL]  = refill;
      e[EXC_INVALID] = invalid;
      e[EXC_MODIFY]  = modify;
      return e;
   endfunction

endpackage

// File: rtl/dt_queue_mem.sv
// rtl/dt_queue_mem.sv - DEPTH x entry storage, one write port and one asynchronous read port
module dt_queue_mem #(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [W-1:0]     wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [W-1:0]     rdata
);

   logic [W-1:0] mem [DEPTH];

   // Contents are never reset; the control logic masks everything outside the occupied range.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dt_queue.sv
// rtl/dt_queue.sv - in-order DTLB-to-DCache request queue with valid/ready handshake
// and single data SRAM issue when each entry leaves the head.
module dt_queue
   import dt_queue_pkg::*;
#(
   parameter int PAYLOAD_W = DT_PAYLOAD_W,
   parameter int TAG_W     = 20,
   parameter int DEPTH     = 2,
   parameter int CNT_W     = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic                 in_uncached,
   input  logic [TAG_W-1:0]     in_tag,
   input  logic                 d_refill,
   input  logic                 d_invalid,
   input  logic                 d_modify,
   input  logic                 in_sram_en,
   input  logic                 in_sram_wen,
   input  logic [3:0]           in_sram_sel,
   input  logic [31:0]          in_sram_addr,
   input  logic [31:0]          in_sram_wdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [2:0]           out_exc,
   output logic                 out_uncached,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 data_sram_en,
   output logic                 data_sram_wen,
   output logic [3:0]           data_sram_sel,
   output logic [31:0]          data_sram_addr,
   output logic [31:0]          data_sram_wdata,
   output logic [CNT_W-1:0]     count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int ENT_W = PAYLOAD_W + DT_EXC_W + 1 + TAG_W + DATA_SRAM_WD;

   logic [CNT_W-1:0]     cnt_q;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 push;
   logic                 pop;
   data_sram_t           wr_sram;
   data_sram_t           hd_sram;
   logic [ENT_W-1:0]     wr_ent;
   logic [ENT_W-1:0]     rd_ent;
   logic [PAYLOAD_W-1:0] hd_payload;
   logic [DT_EXC_W-1:0]  hd_exc;
   logic                 hd_uncached;
   logic [TAG_W-1:0]     hd_tag;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign in_ready  = resetn & (cnt_q < CNT_W'(DEPTH)) & ~flush;
   assign out_valid = (cnt_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign wr_sram = '{en: in_sram_en, wen: in_sram_wen, sel: in_sram_sel,
                      addr: in_sram_addr, wdata: in_sram_wdata};
   assign wr_ent  = {in_payload, dt_pack_exc(d_refill, d_invalid, d_modify),
                     in_uncached, in_tag, wr_sram};

   dt_queue_mem #(
      .W     (ENT_W),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wr_ent),
      .raddr (rd_ptr),
      .rdata (rd_ent)
   );

   assign {hd_payload, hd_exc, hd_uncached, hd_tag, hd_sram} = rd_ent;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         cnt_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign out_payload  = out_valid ? hd_payload  : '0;
   assign out_exc      = out_valid ? hd_exc      : '0;
   assign out_uncached = out_valid & hd_uncached;
   assign out_tag      = out_valid ? hd_tag      : '0;

   // Faulting entries still travel downstream but never touch memory.
   assign data_sram_en    = pop & hd_sram.en & ~|hd_exc & ~flush;
   assign data_sram_wen   = out_valid & hd_sram.wen;
   assign data_sram_sel   = out_valid ? hd_sram.sel   : '0;
   assign data_sram_addr  = out_valid ? hd_sram.addr  : '0;
   assign data_sram_wdata = out_valid ? hd_sram.wdata : '0;
   assign count           = cnt_q;

endmodule

// File: tb/tb_dt_queue.sv
// tb/tb_dt_queue.sv - bench for dt_queue: DEPTH=2 and DEPTH=3 instances against a queue model
module tb_dt_queue;

   localparam int PW = 150;
   localparam int TW = 20;
   localparam int VW = 2 + PW + 3 + 1 + TW + 1 + 1 + 4 + 32 + 32 + 2;

   typedef struct packed {
      logic [PW-1:0] payload;
      logic [2:0]    exc;
      logic          unc;
      logic [TW-1:0] tag;
      logic          en;
      logic          wen;
      logic [3:0]    sel;
      logic [31:0]   addr;
      logic [31:0]   wdata;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn = 1'b0;
   logic flush = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   ent_t drv = '0;

   logic          in_ready2, out_valid2, out_uncached2, data_sram_en2, data_sram_wen2;
   logic [PW-1:0] out_payload2;
   logic [2:0]    out_exc2;
   logic [TW-1:0] out_tag2;
   logic [3:0]    data_sram_sel2;
   logic [31:0]   data_sram_addr2, data_sram_wdata2;
   logic [1:0]    count2;

   logic          in_ready3, out_valid3, out_uncached3, data_sram_en3, data_sram_wen3;
   logic [PW-1:0] out_payload3;
   logic [2:0]    out_exc3;
   logic [TW-1:0] out_tag3;
   logic [3:0]    data_sram_sel3;
   logic [31:0]   data_sram_addr3, data_sram_wdata3;
   logic [1:0]    count3;

   dt_queue #(.PAYLOAD_W(PW), .TAG_W(TW), .DEPTH(2), .CNT_W(2)) dut2 (
      .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
      .in_payload(drv.payload), .in_uncached(drv.unc), .in_tag(drv.tag),
      .d_refill(drv.exc[0]), .d_invalid(drv.exc[1]), .d_modify(drv.exc[2]),
      .in_sram_en(drv.en), .in_sram_wen(drv.wen), .in_sram_sel(drv.sel),
      .in_sram_addr(drv.addr), .in_sram_wdata(drv.wdata),
      .out_valid(out_valid2), .out_ready(out_ready), .out_payload(out_payload2),
      .out_exc(out_exc2), .out_uncached(out_uncached2), .out_tag(out_tag2),
      .data_sram_en(data_sram_en2), .data_sram_wen(data_sram_wen2), .data_sram_sel(data_sram_sel2),
      .data_sram_addr(data_sram_addr2), .data_sram_wdata(data_sram_wdata2), .count(count2)
   );

   dt_queue #(.PAYLOAD_W(PW), .TAG_W(TW), .DEPTH(3), .CNT_W(2)) dut3 (
      .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
      .in_payload(drv.payload), .in_uncached(drv.unc), .in_tag(drv.tag),
      .d_refill(drv.exc[0]), .d_invalid(drv.exc[1]), .d_modify(drv.exc[2]),
      .in_sram_en(drv.en), .in_sram_wen(drv.wen), .in_sram_sel(drv.sel),
      .in_sram_addr(drv.addr), .in_sram_wdata(drv.wdata),
      .out_valid(out_valid3), .out_ready(out_ready), .out_payload(out_payload3),
      .out_exc(out_exc3), .out_uncached(out_uncached3), .out_tag(out_tag3),
      .data_sram_en(data_sram_en3), .data_sram_wen(data_sram_wen3), .data_sram_sel(data_sram_sel3),
      .data_sram_addr(data_sram_addr3), .data_sram_wdata(data_sram_wdata3), .count(count3)
   );

   logic [VW-1:0] obs2, obs3;
   assign obs2 = {in_ready2, out_valid2, out_payload2, out_exc2, out_uncached2, out_tag2,
                  data_sram_en2, data_sram_wen2, data_sram_sel2, data_sram_addr2,
                  data_sram_wdata2, count2};
   assign obs3 = {in_ready3, out_valid3, out_payload3, out_exc3, out_uncached3, out_tag3,
                  data_sram_en3, data_sram_wen3, data_sram_sel3, data_sram_addr3,
                  data_sram_wdata3, count3};

   int total = 0;
   int bad = 0;

   // Reference: one FIFO of whole requests per instance.
   ent_t q2[$];
   ent_t q3[$];

   always @(posedge clk or negedge resetn) begin
      if (!resetn || flush) begin
         q2.delete();
         q3.delete();
      end else begin
         if (in_valid && q2.size() < 2) begin
            if (out_ready && q2.size() != 0) void'(q2.pop_front());
            q2.push_back(drv);
         end else if (out_ready && q2.size() != 0) void'(q2.pop_front());
         if (in_valid && q3.size() < 3) begin
            if (out_ready && q3.size() != 0) void'(q3.pop_front());
            q3.push_back(drv);
         end else if (out_ready && q3.size() != 0) void'(q3.pop_front());
      end
   end

   function automatic logic [VW-1:0] exp_vec(input int d);
      ent_t h;
      int   n;
      logic rdy, vld, en;
      n = (d == 2) ? q2.size() : q3.size();
      h = '0;
      if (n != 0) h = (d == 2) ? q2[0] : q3[0];
      vld = (n != 0);
      rdy = resetn && !flush && (n < d);
      en  = vld && out_ready && h.en && (h.exc == 3'b000) && !flush;
      return {rdy, vld, h.payload, h.exc, h.unc, h.tag, en, h.wen, h.sel, h.addr, h.wdata, 2'(n)};
   endfunction

   function automatic ent_t rand_ent();
      ent_t         e;
      logic [159:0] p;
      p         = {$urandom, $urandom, $urandom, $urandom, $urandom};
      e.payload = p[PW-1:0];
      e.exc     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      e.unc     = 1'($urandom);
      e.tag     = 20'($urandom);
      e.en      = 1'($urandom);
      e.wen     = 1'($urandom);
      e.sel     = 4'($urandom);
      e.addr    = $urandom;
      e.wdata   = $urandom;
      return e;
   endfunction

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      resetn = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      drv = rand_ent(); drv.en = 1'b1; drv.exc = 3'b000;
      #1;
      total++; if (obs2 !== exp_vec(2)) begin bad++; $display("FAIL reset_vec2 got=%h exp=%h", obs2, exp_vec(2)); end
      total++; if (in_ready2 !== 1'b0 || data_sram_en2 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", in_ready2, data_sram_en2); end
      @(posedge clk); #1;
      total++; if (count2 !== 2'd0 || out_valid2 !== 1'b0) begin bad++; $display("FAIL reset_hold count=%0d valid=%b exp 0/0", count2, out_valid2); end
      @(negedge clk);
      resetn = 1'b1; in_valid = 1'b0;
      #1;
      total++; if (obs3 !== exp_vec(3)) begin bad++; $display("FAIL reset_rel3 got=%h exp=%h", obs3, exp_vec(3)); end
   endtask

   task automatic test_single();
      int          n_en = 0;
      logic [31:0] a = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         flush = 1'b0; out_ready = 1'b1; in_valid = (c == 0);
         if (c == 0) begin
            drv = rand_ent(); drv.exc = 3'b000; drv.en = 1'b1; drv.wen = 1'b0; drv.addr = 32'h1000_0040;
         end
         #1;
         total++; if (obs2 !== exp_vec(2)) begin bad++; $display("FAIL single_c%0d got=%h exp=%h", c, obs2, exp_vec(2)); end
         if (data_sram_en2) begin n_en++; a = data_sram_addr2; end
         if (c == 1) begin
            total++; if (out_valid2 !== 1'b1 || count2 !== 2'd1) begin bad++; $display("FAIL single_lat valid=%b count=%0d exp 1/1", out_valid2, count2); end
         end
      end
      total++; if (n_en != 1 || a !== 32'h1000_0040) begin bad++; $display("FAIL single_issue pulses=%0d addr=%h exp 1/10000040", n_en, a); end
      total++; if (count2 !== 2'd0) begin bad++; $display("FAIL single_drain count=%0d exp=0", count2); end
   endtask

   task automatic test_backpressure();
      ent_t        e[3];
      logic [31:0] popped[$];
      int          k = 0;
      for (int i = 0; i < 3; i++) begin e[i] = rand_ent(); e[i].exc = 3'b000; e[i].addr = 32'hA000_0000 + 32'(i); end
      do_flush();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         flush = 1'b0; out_ready = (c >= 4); in_valid = (k < 3);
         if (k < 3) drv = e[k];
         #1;
         total++; if (obs2 !== exp_vec(2)) begin bad++; $display("FAIL bp_c%0d got=%h exp=%h", c, obs2, exp_vec(2)); end
         if (c == 3) begin
            total++; if (in_ready2 !== 1'b0 || count2 !== 2'd2) begin bad++; $display("FAIL bp_full ready=%b count=%0d exp 0/2", in_ready2, count2); end
         end
         if (out_valid2 && out_ready) popped.push_back(data_sram_addr2);
         if (k < 3 && q2.size() < 2) k++;
      end
      total++;
      if (popped.size() != 3 || popped[0] !== e[0].addr || popped[1] !== e[1].addr || popped[2] !== e[2].addr) begin
         bad++; $display("FAIL bp_order n=%0d exp 3 in order A,B,C", popped.size());
      end
   endtask

   task automatic test_exc();
      int         n_en = 0;
      logic [2:0] seen = '0;
      do_flush();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         flush = 1'b0; out_ready = 1'b1; in_valid = (c == 0);
         if (c == 0) begin drv = rand_ent(); drv.exc = 3'b100; drv.en = 1'b1; drv.wen = 1'b1; end
         #1;
         total++; if (obs2 !== exp_vec(2)) begin bad++; $display("FAIL exc_c%0d got=%h exp=%h", c, obs2, exp_vec(2)); end
         if (data_sram_en2) n_en++;
         if (out_valid2) seen = out_exc2;
      end
      total++; if (n_en != 0 || seen !== 3'b100) begin bad++; $display("FAIL exc_suppress pulses=%0d exc=%b exp 0/100", n_en, seen); end
   endtask

   task automatic test_back_to_back();
      ent_t        e[8];
      logic [31:0] iss[$];
      int          cyc[$];
      int          k = 0;
      int          ok = 1;
      for (int i = 0; i < 8; i++) begin
         e[i] = rand_ent(); e[i].exc = 3'b000; e[i].en = 1'b1; e[i].addr = 32'h2000_0000 + 32'(i * 4);
      end
      do_flush();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         flush = 1'b0; out_ready = 1'b1; in_valid = (k < 8);
         if (k < 8) drv = e[k];
         #1;
         total++; if (obs2 !== exp_vec(2)) begin bad++; $display("FAIL b2b_c%0d got=%h exp=%h", c, obs2, exp_vec(2)); end
         if (data_sram_en2) begin iss.push_back(data_sram_addr2); cyc.push_back(c); end
         if (k < 8 && q2.size() < 2) k++;
      end
      if (iss.size() != 8) ok = 0;
      else for (int i = 0; i < 8; i++) if (iss[i] !== e[i].addr || cyc[i] != cyc[0] + i) ok = 0;
      total++; if (ok == 0) begin bad++; $display("FAIL b2b_stream issued=%0d ordered_no_gap=%0d exp 8/1", iss.size(), ok); end
   endtask

   task automatic test_flush();
      int n_en = 0;
      do_flush();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         flush = (c == 2); in_valid = (c <= 2); out_ready = (c >= 2);
         drv = rand_ent(); drv.exc = 3'b000; drv.en = 1'b1;
         #1;
         total++; if (obs2 !== exp_vec(2)) begin bad++; $display("FAIL flush_c%0d got=%h exp=%h", c, obs2, exp_vec(2)); end
         if (data_sram_en2) n_en++;
         if (c == 3) begin
            total++; if (count2 !== 2'd0 || out_valid2 !== 1'b0) begin bad++; $display("FAIL flush_empty count=%0d valid=%b exp 0/0", count2, out_valid2); end
         end
      end
      total++; if (n_en != 0) begin bad++; $display("FAIL flush_issue pulses=%0d exp=0", n_en); end
   endtask

   task automatic test_wrap();
      ent_t          e[9];
      logic [PW-1:0] got[$];
      int            k = 0;
      int            ok = 1;
      for (int i = 0; i < 9; i++) e[i] = rand_ent();
      do_flush();
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         flush = 1'b0; out_ready = (c >= 2); in_valid = (k < 9);
         if (k < 9) drv = e[k];
         #1;
         total++; if (obs3 !== exp_vec(3)) begin bad++; $display("FAIL wrap_c%0d got=%h exp=%h", c, obs3, exp_vec(3)); end
         if (out_valid3 && out_ready) got.push_back(out_payload3);
         if (k < 9 && q3.size() < 3) k++;
      end
      if (got.size() != 9) ok = 0;
      else for (int i = 0; i < 9; i++) if (got[i] !== e[i].payload) ok = 0;
      total++; if (ok == 0) begin bad++; $display("FAIL wrap_order popped=%0d in_order=%0d exp 9/1", got.size(), ok); end
   endtask

   task automatic test_random();
      do_flush();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         resetn    = !(c == 200 || c == 201);
         flush     = ($urandom_range(0, 19) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         drv       = rand_ent();
         #1;
         total++; if (obs2 !== exp_vec(2)) begin bad++; $display("FAIL rand2_c%0d got=%h exp=%h", c, obs2, exp_vec(2)); end
         total++; if (obs3 !== exp_vec(3)) begin bad++; $display("FAIL rand3_c%0d got=%h exp=%h", c, obs3, exp_vec(3)); end
      end
      @(negedge clk);
      resetn = 1'b1; flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_exc();
      test_back_to_back();
      test_flush();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dt_queue.md
Name: dt_queue

Overview:
- Parametrised successor to the DTLB→DCache stage register.
- Holds translated data-memory requests in a DEPTH-entry in-order queue.
- Uses a valid/ready handshake instead of the stall bus. Merges the TLB exception flags into each entry and issues the data SRAM request exactly once, when the entry leaves the queue.
- Sits between dtlb and the dcache-result stage; DEPTH=1 gives register-like behaviour with backpressure.

Parameters:
- PAYLOAD_W, 150, width of opaque pipeline payload passed to dcache stage
- TAG_W, 20, physical tag width
- DEPTH, 2, queue entries (≥1; power of two not required)
- CNT_W, 2, width of occupancy count, must hold DEPTH

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- flush  in  1  exception/ertn flush, synchronous
- in_valid  in  1  dtlb has a request
- in_ready  out  1  queue can accept
- in_payload  in  PAYLOAD_W  pipeline payload
- in_uncached  in  1  uncached attribute
- in_tag  in  TAG_W  physical tag
- d_refill  in  1  TLB refill exception for in_* request
- d_invalid  in  1  TLB invalid exception
- d_modify  in  1  TLB modify exception
- in_sram_en  in  1  request wants memory access
- in_sram_wen  in  1  write
- in_sram_sel  in  4  byte select
- in_sram_addr  in  32  physical address
- in_sram_wdata  in  32  store data
- out_valid  out  1  head entry present
- out_ready  in  1  downstream accepts head
- out_payload  out  PAYLOAD_W  head payload
- out_exc  out  3  head {modify, invalid, refill}
- out_uncached  out  1  head uncached
- out_tag  out  TAG_W  head tag
- data_sram_en  out  1  SRAM request strobe
- data_sram_wen  out  1  SRAM write
- data_sram_sel  out  4  SRAM byte select
- data_sram_addr  out  32  SRAM address
- data_sram_wdata  out  32  SRAM write data
- count  out  CNT_W  current occupancy

Behaviour:
- Entry contents: {payload, exc[2:0], uncached, tag, sram_en, wen, sel, addr, wdata}, captured on push. exc is taken from the d_* inputs in the same cycle.
- Push when in_valid & in_ready. Pop when out_valid & out_ready.
- in_ready = (count < DEPTH) & ~flush. It is registered-state derived only, with no combinational path from out_ready.
- out_valid = (count != 0). Head fields are driven from the read pointer. All out_* fields are 0 when out_valid=0 (bubble semantics).
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, push is blocked even if a pop occurs, giving one bubble; DEPTH≥2 sustains 1 req/cycle.
- Pointers wrap modulo DEPTH, including non-power-of-two DEPTH (explicit compare to DEPTH-1).
- Latency: a push at cycle N is visible at out_* in cycle N+1 when the queue was empty. There is no bypass.
- SRAM issue is combinational from the head:
  - data_sram_en = out_valid & out_ready & head.sram_en & ~|head.exc
  - wen/sel/addr/wdata = head fields when out_valid, else 0
  - Each entry issues at most once, in program order.
- Exception entries still pop to downstream with out_exc set so the later stage raises the exception. Their SRAM strobe is suppressed.
- flush (has priority over push and pop):
  - count→0, pointers→0, flush-cycle input dropped.
  - data_sram_en is forced 0 in the flush cycle.
  - Entry storage need not be cleared.
- Reset (resetn=0, asynchronous):
  - count=0, pointers=0, out_valid=0, in_ready=0 while asserted, all data_sram_* = 0.
  - Release mid-operation is safe: the queue comes up empty.
- Push when count==DEPTH cannot occur (in_ready=0); the bench asserts this.

Decomposition:
- Shared package or defines.vh holds:
  - DT_EXC_W=3 and exc bit indices REFILL=0, INVALID=1, MODIFY=2
  - DATA_SRAM_WD=70 and its field order
  - the default PAYLOAD_W
- One natural sub-module: dt_queue_mem, the DEPTH×entry storage with write/read pointer ports. The control logic (count, pointers, issue gating) stays in dt_queue.

Test Plan:
- Reset, then push addr=0x1000_0040, en=1, wen=0, no exc, out_ready=1 → out_valid in next cycle; data_sram_en=1 for exactly one cycle with addr 0x1000_0040; count 1→0.
- DEPTH=2, out_ready=0, push A, B, C → A and B accepted; in_ready=0 at count=2 and C is held. Then out_ready=1 → A and B pop in order, and C is accepted on the cycle count drops.
- Push with d_modify=1, sram_en=1, wen=1 → entry pops with out_exc=3'b100; data_sram_en stays 0 throughout.
- Continuous in_valid and out_ready with DEPTH=2 → one request per cycle for 8 cycles; addresses are issued in order with no gaps.
- Two entries queued, then flush asserted with in_valid=1 → next cycle count=0 and out_valid=0; the flush-cycle request never appears and no data_sram_en fires.
- DEPTH=3 with 7 push/pop pairs → pointer wrap at index 2→0 is correct; payload order is preserved.
